// File: rtl/mr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encodings and default
// datapath widths. Imported by mr_fetch_unit and usable by its neighbours
// (mrcontrolunit, program memory model) so the encodings stay in one place.
package mr_fetch_unit_pkg;

  localparam int MR_DW = 16;  // default instruction word width
  localparam int MR_AW = 16;  // default program address width

  // Encoding 2'd3 is unreachable; the FSM recovers from it to S_REQ.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // I valid, no request outstanding
    S_REQ   = 2'd1,  // request outstanding, result will be kept
    S_FLUSH = 2'd2   // request outstanding, result will be discarded
  } fetch_state_t;

endpackage : mr_fetch_unit_pkg

// File: rtl/mr_fetch_unit.sv
// Instruction fetch stage feeding mrcontrolunit.
// Holds the program counter, fetches instruction words from program memory
// over a REQ/ACK handshake and presents the current word on I with I_VALID.
//
// Ports
//   CLK        in   1   clock, all state on rising edge
//   RST        in   1   asynchronous active-low reset
//   PC_E       in   1   advance request (one-cycle pulse)
//   J          in   1   jump request, qualifies J_TARGET (wins over PC_E)
//   J_TARGET   in   AW  jump destination
//   IMEM_REQ   out  1   program memory read request
//   IMEM_ADDR  out  AW  read address, stable while a request is un-acked
//   IMEM_ACK   in   1   read complete, IMEM_DATA valid this cycle
//   IMEM_DATA  in   DW  read data
//   I          out  DW  current instruction (registered)
//   I_VALID    out  1   I holds the word at PC
//   PC         out  AW  current program counter
//   ERR        out  1   sticky protocol error (PC_E while I_VALID=0)
module mr_fetch_unit
  import mr_fetch_unit_pkg::*;
#(
  parameter int              DW         = MR_DW,
  parameter int              AW         = MR_AW,
  parameter logic [AW-1:0]   RESET_ADDR = '0,
  parameter int              STEP       = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PC_E,
  input  logic          J,
  input  logic [AW-1:0] J_TARGET,
  output logic          IMEM_REQ,
  output logic [AW-1:0] IMEM_ADDR,
  input  logic          IMEM_ACK,
  input  logic [DW-1:0] IMEM_DATA,
  output logic [DW-1:0] I,
  output logic          I_VALID,
  output logic [AW-1:0] PC,
  output logic          ERR
);

  localparam logic [AW-1:0] STEP_W = AW'(STEP);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] i_q, i_d;
  logic          i_valid_q, i_valid_d;
  logic          err_q, err_d;
  // The reset state is S_REQ, but the request must stay low while reset is
  // held and only rise on the first clock after release; req_en provides that.
  logic          req_en_q;

  logic [AW-1:0] pc_inc;
  logic          ack_ok;

  // Carry-out of the increment is dropped: PC wraps modulo 2^AW.
  assign pc_inc = pc_q + STEP_W;
  // ACK only counts while a request is actually being driven.
  assign ack_ok = IMEM_REQ && IMEM_ACK;

  // State register.
  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values together; blocking = would let later statements see
  // already-updated state and create order-dependent behaviour.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_ADDR;
      addr_q    <= RESET_ADDR;
      i_q       <= '0;
      i_valid_q <= 1'b0;
      err_q     <= 1'b0;
      req_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      i_q       <= i_d;
      i_valid_q <= i_valid_d;
      err_q     <= err_d;
      req_en_q  <= 1'b1;
    end
  end

  // Next-state and next-datapath logic.
  // NOTE: every signal assigned below gets a hold-value default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    i_d       = i_q;
    i_valid_d = i_valid_q;
    err_d     = err_q;

    // Advancing while the controller should be stalled is a protocol error;
    // the request itself is dropped.
    if (PC_E && !i_valid_q && !J) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (J) begin
          pc_d      = J_TARGET;
          addr_d    = J_TARGET;
          i_valid_d = 1'b0;
          state_d   = S_REQ;
        end else if (PC_E) begin
          pc_d      = pc_inc;
          addr_d    = pc_inc;
          i_valid_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (J) begin
          pc_d = J_TARGET;
          // The address must stay put until the memory acks; if it acks on
          // this very edge we can retarget immediately and skip S_FLUSH.
          if (ack_ok) addr_d  = J_TARGET;
          else        state_d = S_FLUSH;
        end else if (ack_ok) begin
          i_d       = IMEM_DATA;
          i_valid_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (J) pc_d = J_TARGET;
        // Stale data is discarded; reissue at the newest PC (a jump on the
        // same edge is already folded into pc_d).
        if (ack_ok) begin
          addr_d  = pc_d;
          state_d = S_REQ;
        end
      end
      default: begin
        i_valid_d = 1'b0;
        state_d   = S_REQ;
      end
    endcase
  end

  // Outputs, decoded from registered state only.
  always_comb begin
    IMEM_REQ  = req_en_q && (state_q != S_IDLE);
    IMEM_ADDR = addr_q;
    I         = i_q;
    I_VALID   = i_valid_q;
    PC        = pc_q;
    ERR       = err_q;
  end

endmodule : mr_fetch_unit

// File: tb/tb_mr_fetch_unit.sv
// Directed bench for mr_fetch_unit. Inputs change 1 time unit after a rising
// edge; registered outputs are checked at that same point.
module tb_mr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PC_E;
  logic        J;
  logic [15:0] J_TARGET;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [15:0] IMEM_DATA;
  logic [15:0] I;
  logic        I_VALID;
  logic [15:0] PC;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  mr_fetch_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .PC_E      (PC_E),
    .J         (J),
    .J_TARGET  (J_TARGET),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_ACK  (IMEM_ACK),
    .IMEM_DATA (IMEM_DATA),
    .I         (I),
    .I_VALID   (I_VALID),
    .PC        (PC),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; PC_E = 1'b0; J = 1'b0; J_TARGET = '0;
    IMEM_ACK = 1'b0; IMEM_DATA = '0;

    // 1. Reset, first fetch from 0x0000 with zero-wait ack.
    step(); step();
    check("rst_req",     IMEM_REQ, 0);
    check("rst_i",       I,        16'h0000);
    check("rst_valid",   I_VALID,  0);
    check("rst_pc",      PC,       16'h0000);
    check("rst_err",     ERR,      0);
    RST = 1'b1;
    step();
    check("t1_req",      IMEM_REQ,  1);
    check("t1_addr",     IMEM_ADDR, 16'h0000);
    IMEM_ACK = 1'b1; IMEM_DATA = 16'h1234;
    step();
    IMEM_ACK = 1'b0; IMEM_DATA = 16'hFFFF;
    check("t1_i",        I,        16'h1234);
    check("t1_valid",    I_VALID,  1);
    check("t1_req_done", IMEM_REQ, 0);

    // 2. PC_E, ack delayed three cycles; address stable throughout.
    PC_E = 1'b1;
    step();
    PC_E = 1'b0;
    check("t2_pc",    PC, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      check("t2_addr_hold",  IMEM_ADDR, 16'h0001);
      check("t2_i_hold",     I,         16'h1234);
      check("t2_valid_low",  I_VALID,   0);
      check("t2_req_hold",   IMEM_REQ,  1);
      step();
    end
    check("t2_addr_last", IMEM_ADDR, 16'h0001);
    check("t2_i_before",  I,         16'h1234);
    IMEM_ACK = 1'b1; IMEM_DATA = 16'h5678;
    step();
    IMEM_ACK = 1'b0;
    check("t2_i",     I,       16'h5678);
    check("t2_valid", I_VALID, 1);

    // 3. J and PC_E together in S_IDLE: jump wins, no increment, no error.
    J = 1'b1; PC_E = 1'b1; J_TARGET = 16'h00F0;
    step();
    J = 1'b0; PC_E = 1'b0;
    check("t3_pc",   PC,        16'h00F0);
    check("t3_addr", IMEM_ADDR, 16'h00F0);
    check("t3_err",  ERR,       0);
    IMEM_ACK = 1'b1; IMEM_DATA = 16'h0AAA;
    step();
    IMEM_ACK = 1'b0;
    check("t3_valid", I_VALID, 1);
    check("t3_i",     I,       16'h0AAA);

    // 4. Jump while request to 0x0003 is outstanding; stale data dropped.
    J = 1'b1; J_TARGET = 16'h0003;
    step();
    check("t4_addr0", IMEM_ADDR, 16'h0003);
    J_TARGET = 16'h0100;
    step();
    J = 1'b0;
    check("t4_pc",        PC,        16'h0100);
    check("t4_addr_hold", IMEM_ADDR, 16'h0003);
    check("t4_req",       IMEM_REQ,  1);
    IMEM_ACK = 1'b1; IMEM_DATA = 16'hDEAD;
    step();
    check("t4_no_dead",   I,         16'h0AAA);
    check("t4_valid_low", I_VALID,   0);
    check("t4_addr_new",  IMEM_ADDR, 16'h0100);
    check("t4_req_new",   IMEM_REQ,  1);
    IMEM_DATA = 16'hBEEF;
    step();
    IMEM_ACK = 1'b0;
    check("t4_i",     I,       16'hBEEF);
    check("t4_valid", I_VALID, 1);

    // 4b. Jump on the same edge as an ack in S_REQ: retarget at once.
    J = 1'b1; J_TARGET = 16'h0200;
    step();
    J_TARGET = 16'h0300; IMEM_ACK = 1'b1; IMEM_DATA = 16'hDEAD;
    step();
    J = 1'b0;
    check("t4b_pc",    PC,        16'h0300);
    check("t4b_addr",  IMEM_ADDR, 16'h0300);
    check("t4b_i",     I,         16'hBEEF);
    check("t4b_valid", I_VALID,   0);
    IMEM_DATA = 16'h3333;
    step();
    IMEM_ACK = 1'b0;
    check("t4b_i_new", I, 16'h3333);

    // 5. PC wraps from 0xFFFF to 0x0000; ack while idle is ignored.
    J = 1'b1; J_TARGET = 16'hFFFF;
    step();
    J = 1'b0; IMEM_ACK = 1'b1; IMEM_DATA = 16'h7777;
    step();
    IMEM_DATA = 16'h9999;
    step();
    IMEM_ACK = 1'b0;
    check("t5_idle_ack", I, 16'h7777);
    check("t5_req_idle", IMEM_REQ, 0);
    PC_E = 1'b1;
    step();
    PC_E = 1'b0;
    check("t5_pc_wrap",   PC,        16'h0000);
    check("t5_addr_wrap", IMEM_ADDR, 16'h0000);
    IMEM_ACK = 1'b1; IMEM_DATA = 16'h0101;
    step();
    IMEM_ACK = 1'b0;
    check("t5_i", I, 16'h0101);

    // 6. PC_E while stalled sets sticky ERR; reset mid-request clears all.
    PC_E = 1'b1;
    step();
    check("t6_pc1", PC, 16'h0001);
    step();
    PC_E = 1'b0;
    check("t6_err",     ERR, 1);
    check("t6_pc_same", PC,  16'h0001);
    step();
    check("t6_err_sticky", ERR,      1);
    check("t6_req_before", IMEM_REQ, 1);
    RST = 1'b0;
    #1;
    check("t6_rst_req",   IMEM_REQ, 0);
    check("t6_rst_err",   ERR,      0);
    check("t6_rst_pc",    PC,       16'h0000);
    check("t6_rst_valid", I_VALID,  0);
    check("t6_rst_i",     I,        16'h0000);
    #1;
    RST = 1'b1;
    step();
    check("t6_req_again",  IMEM_REQ,  1);
    check("t6_addr_again", IMEM_ADDR, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mr_fetch_unit
